smpl_cnt_chk: RTL

Parametrised per-triangle sample-count checker, the successor to the single-lane sample count scoreboard. It sits after the sample-test/hash stages of the rasterizer bench. It accepts an expected hit count per triangle, tallies tagged hits arriving on LANES parallel sample lanes, and on each end-of-triangle marker compares the tally against the expected count. It reports per-triangle pass/fail plus saturating and sticky error status; it uses no DPI, so it can run in emulation.

---
 rtl/smpl_cnt_chk_if.sv | 41 ++++
 rtl/smpl_cnt_chk.sv | 132 +++++++++++++
 2 files changed

// File: rtl/smpl_cnt_chk_if.sv
// rtl/smpl_cnt_chk_if.sv - expected/hit/done/result bundle for the sample-count checker
interface smpl_cnt_chk_if #(
  parameter int LANES = 4,
  parameter int ID_W  = 8,
  parameter int CNT_W = 20,
  parameter int DEPTH = 8,
  parameter int ERR_W = 16
);
  logic                     exp_valid_i;
  logic [ID_W-1:0]          exp_id_i;
  logic [CNT_W-1:0]         exp_cnt_i;
  logic                     exp_ready_o;
  logic [LANES-1:0]         hit_valid_i;
  logic [LANES*ID_W-1:0]    hit_id_i;
  logic                     done_valid_i;
  logic [ID_W-1:0]          done_id_i;
  logic                     res_valid_o;
  logic [ID_W-1:0]          res_id_o;
  logic [CNT_W-1:0]         res_cnt_o;
  logic [CNT_W-1:0]         res_exp_o;
  logic                     res_pass_o;
  logic [ERR_W-1:0]         err_cnt_o;
  logic                     ovf_o;
  logic                     unf_o;
  logic                     tag_err_o;
  logic [$clog2(DEPTH):0]   occ_o;

  modport master (
    output exp_valid_i, exp_id_i, exp_cnt_i, hit_valid_i, hit_id_i,
           done_valid_i, done_id_i,
    input  exp_ready_o, res_valid_o, res_id_o, res_cnt_o, res_exp_o,
           res_pass_o, err_cnt_o, ovf_o, unf_o, tag_err_o, occ_o
  );

  modport slave (
    input  exp_valid_i, exp_id_i, exp_cnt_i, hit_valid_i, hit_id_i,
           done_valid_i, done_id_i,
    output exp_ready_o, res_valid_o, res_id_o, res_cnt_o, res_exp_o,
           res_pass_o, err_cnt_o, ovf_o, unf_o, tag_err_o, occ_o
  );
endinterface

// File: rtl/smpl_cnt_chk.sv
// rtl/smpl_cnt_chk.sv - per-triangle multi-lane hit tally checked against a FIFO of expected counts
module smpl_cnt_chk #(
  parameter int LANES = 4,
  parameter int ID_W  = 8,
  parameter int CNT_W = 20,
  parameter int DEPTH = 8,
  parameter int ERR_W = 16
) (
  input  logic clk,
  input  logic rst,
  smpl_cnt_chk_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int LW = $clog2(LANES + 1);
  localparam int SW = CNT_W + LW;

  logic [ID_W-1:0]  id_mem  [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic             ready_q;
  logic [CNT_W-1:0] tally_q, tally_d;
  logic             res_valid_q;
  logic [ID_W-1:0]  res_id_q;
  logic [CNT_W-1:0] res_cnt_q, res_exp_q;
  logic             res_pass_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ovf_q, unf_q, tag_q;

  logic             empty, full, pop, push, ovf_ev, unf_ev, fail_ev, pass;
  logic [ID_W-1:0]  head_id;
  logic [CNT_W-1:0] head_cnt, tally_fin;
  logic [LW-1:0]    add;
  logic             bad;
  logic [SW-1:0]    sum;
  logic [1:0]       errs;
  logic [ERR_W:0]   err_sum;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == OW'(DEPTH));
  assign head_id  = id_mem[rd_ptr_q];
  assign head_cnt = cnt_mem[rd_ptr_q];

  // A lane counts only if it carries the head's tag; any other valid lane is a tag error.
  always_comb begin
    add = '0;
    bad = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (bus.hit_valid_i[k]) begin
        if (!empty && (bus.hit_id_i[k*ID_W +: ID_W] == head_id))
          add = add + LW'(1);
        else
          bad = 1'b1;
      end
    end
  end

  assign sum       = SW'(tally_q) + SW'(add);
  assign tally_fin = (|sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  assign pop     = bus.done_valid_i && !empty;
  assign push    = bus.exp_valid_i && (!full || pop);
  assign ovf_ev  = bus.exp_valid_i && full && !pop;
  assign unf_ev  = bus.done_valid_i && empty;
  assign pass    = (tally_fin == head_cnt) && (bus.done_id_i == head_id);
  assign fail_ev = pop && !pass;

  assign errs    = 2'(ovf_ev) + 2'(bad) + 2'(fail_ev || unf_ev);
  assign err_sum = {1'b0, err_q} + (ERR_W+1)'(errs);
  assign err_d   = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

  assign occ_d   = occ_q + OW'(push) - OW'(pop);
  assign tally_d = pop ? '0 : tally_fin;

  // Storage has no reset; entries are only ever read below occupancy.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      id_mem[wr_ptr_q]  <= bus.exp_id_i;
      cnt_mem[wr_ptr_q] <= bus.exp_cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      ready_q     <= 1'b1;
      tally_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
      res_exp_q   <= '0;
      res_pass_q  <= 1'b0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      tag_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q       <= occ_d;
      ready_q     <= (occ_d != OW'(DEPTH));
      tally_q     <= tally_d;
      res_valid_q <= pop;
      if (pop) begin
        res_id_q   <= head_id;
        res_cnt_q  <= tally_fin;
        res_exp_q  <= head_cnt;
        res_pass_q <= pass;
      end
      err_q <= err_d;
      if (ovf_ev) ovf_q <= 1'b1;
      if (unf_ev) unf_q <= 1'b1;
      if (bad)    tag_q <= 1'b1;
    end
  end

  assign bus.exp_ready_o = ready_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_id_o    = res_id_q;
  assign bus.res_cnt_o   = res_cnt_q;
  assign bus.res_exp_o   = res_exp_q;
  assign bus.res_pass_o  = res_pass_q;
  assign bus.err_cnt_o   = err_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.unf_o       = unf_q;
  assign bus.tag_err_o   = tag_q;
  assign bus.occ_o       = occ_q;
endmodule
